// File: rtl/mdu_defs.sv
// Shared definitions for the EX-stage multiply/divide unit: MD opcodes,
// FSM states and default latencies.
package mdu_defs;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MFHI  = 4'd7,
      MD_MFLO  = 4'd8
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   localparam int unsigned MD_MULT_CYCLES_DEF = 5;
   localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

   // Opcodes that occupy the unit for a multi-cycle busy window.
   function automatic logic md_is_start(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_div(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit datapath: signed/unsigned product and signed/unsigned
// quotient/remainder. res_o is {HI,LO}; wr_o is low when the result must not
// be committed (divide by zero).
module mdu_calc
   import mdu_defs::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] res_o,
   output logic        wr_o
);

   logic signed [63:0] sprod;
   logic        [63:0] uprod;
   logic               div_zero;
   logic               div_ovf;
   logic signed [31:0] sdiv_b;
   logic signed [31:0] squot;
   logic signed [31:0] srem;
   logic        [31:0] udiv_b;
   logic        [31:0] uquot;
   logic        [31:0] urem;

   assign sprod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
   assign uprod = {32'd0, a_i} * {32'd0, b_i};

   assign div_zero = (b_i == '0);
   assign div_ovf  = (a_i == 32'h8000_0000) && (b_i == '1);

   // Dividing by 1 instead of -1 in the overflow case yields exactly the
   // required LO=0x80000000, HI=0 without an extra result mux; the zero
   // divisor is likewise replaced so the divider never sees zero.
   assign sdiv_b = (div_zero || div_ovf) ? 32'sd1 : $signed(b_i);
   assign udiv_b = div_zero ? 32'd1 : b_i;

   assign squot = $signed(a_i) / sdiv_b;
   assign srem  = $signed(a_i) % sdiv_b;
   assign uquot = a_i / udiv_b;
   assign urem  = a_i % udiv_b;

   // Select the result for the requested operation.
   always_comb begin
      res_o = '0;
      wr_o  = 1'b0;
      case (op_i)
         MD_MULT: begin
            res_o = sprod;
            wr_o  = 1'b1;
         end
         MD_MULTU: begin
            res_o = uprod;
            wr_o  = 1'b1;
         end
         MD_DIV: begin
            res_o = {srem, squot};
            wr_o  = !div_zero;
         end
         MD_DIVU: begin
            res_o = {urem, uquot};
            wr_o  = !div_zero;
         end
         default: begin
            res_o = '0;
            wr_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: IDLE/RUN FSM with a latency down-counter,
// 64-bit shadow result, architectural HI/LO and the ID stall request.
module ex_mdu
   import mdu_defs::*;
#(
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  EX_MDOp,
   input  logic [31:0] EX_A,
   input  logic [31:0] EX_B,
   input  logic        ID_isMD,
   output logic        MD_busy,
   output logic        MD_start,
   output logic        MD_stall,
   output logic [31:0] MD_out,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

   md_state_e     state_q;
   logic          busy_q;
   logic [CW-1:0] cnt_q;
   logic [63:0]   shadow_q;
   logic          shadow_wr_q;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;

   logic [63:0]   calc_res;
   logic          calc_wr;

   mdu_calc u_calc (
      .op_i  (EX_MDOp),
      .a_i   (EX_A),
      .b_i   (EX_B),
      .res_o (calc_res),
      .wr_o  (calc_wr)
   );

   assign MD_start = md_is_start(EX_MDOp);
   assign MD_busy  = busy_q;
   assign MD_stall = ID_isMD & (MD_start | busy_q);
   assign HI       = hi_q;
   assign LO       = lo_q;

   // mfhi/mflo read path into the EX result mux.
   always_comb begin
      MD_out = '0;
      if (EX_MDOp == MD_MFHI) begin
         MD_out = hi_q;
      end else if (EX_MDOp == MD_MFLO) begin
         MD_out = lo_q;
      end
   end

   // FSM, latency counter, shadow capture and HI/LO update.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
         shadow_q    <= '0;
         shadow_wr_q <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (MD_start) begin
                  shadow_q    <= calc_res;
                  shadow_wr_q <= calc_wr;
                  cnt_q       <= md_is_div(EX_MDOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                  state_q     <= RUN;
                  busy_q      <= 1'b1;
               end else if (EX_MDOp == MD_MTHI) begin
                  hi_q <= EX_A;
               end else if (EX_MDOp == MD_MTLO) begin
                  lo_q <= EX_A;
               end
            end
            RUN: begin
               // Requests arriving here are dropped; the stall keeps them away.
               if (cnt_q == CW'(1)) begin
                  if (shadow_wr_q) begin
                     hi_q <= shadow_q[63:32];
                     lo_q <= shadow_q[31:0];
                  end
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed scenarios followed by random
// traffic, all compared cycle by cycle against an arithmetic reference model.
module tb_ex_mdu;

   localparam int unsigned NMUL = 5;
   localparam int unsigned NDIV = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  EX_MDOp;
   logic [31:0] EX_A;
   logic [31:0] EX_B;
   logic        ID_isMD;
   logic        MD_busy;
   logic        MD_start;
   logic        MD_stall;
   logic [31:0] MD_out;
   logic [31:0] HI;
   logic [31:0] LO;

   ex_mdu #(.MULT_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
      .clk      (clk),
      .reset    (reset),
      .EX_MDOp  (EX_MDOp),
      .EX_A     (EX_A),
      .EX_B     (EX_B),
      .ID_isMD  (ID_isMD),
      .MD_busy  (MD_busy),
      .MD_start (MD_start),
      .MD_stall (MD_stall),
      .MD_out   (MD_out),
      .HI       (HI),
      .LO       (LO)
   );

   always #5 clk = ~clk;

   int unsigned ntests = 0;
   int unsigned nfail  = 0;

   // Reference model state: architectural HI/LO, cycles of busy left,
   // and the result waiting to appear at the end of the busy window.
   logic [31:0] m_hi, m_lo;
   int unsigned m_left;
   logic [63:0] m_pend;
   logic        m_pend_wr;

   logic        last_stall;
   logic        last_start;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference result of a start opcode: {HI,LO} and whether it is written.
   task automatic ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [63:0] res, output logic wr);
      longint      sa, sb, sq, sr;
      logic [63:0] ua, ub;
      sa  = $signed(a);
      sb  = $signed(b);
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      res = '0;
      wr  = 1'b1;
      case (op)
         4'd1: res = sa * sb;
         4'd2: res = ua * ub;
         4'd3: begin
            if (b == 0) wr = 1'b0;
            else begin
               sq  = sa / sb;
               sr  = sa % sb;
               res = {sr[31:0], sq[31:0]};
            end
         end
         default: begin
            if (b == 0) wr = 1'b0;
            else res = {a % b, a / b};
         end
      endcase
   endtask

   // One clock cycle: check registered outputs, drive inputs, check the
   // combinational outputs, advance the model, then cross the clock edge.
   task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic is_md, input logic rst);
      logic        exp_start;
      logic [31:0] exp_out;
      logic [63:0] r;
      logic        w;
      chk("HI", 64'(HI), 64'(m_hi));
      chk("LO", 64'(LO), 64'(m_lo));
      chk("MD_busy", 64'(MD_busy), 64'(m_left != 0));
      reset   = rst;
      EX_MDOp = op;
      EX_A    = a;
      EX_B    = b;
      ID_isMD = is_md;
      #1;
      exp_start = (op >= 4'd1) && (op <= 4'd4);
      exp_out   = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
      chk("MD_start", 64'(MD_start), 64'(exp_start));
      chk("MD_stall", 64'(MD_stall), 64'(is_md && (exp_start || m_left != 0)));
      chk("MD_out", 64'(MD_out), 64'(exp_out));
      last_stall = MD_stall;
      last_start = MD_start;
      if (!rst && m_left != 0 && op >= 4'd1 && op <= 4'd6) begin
         nfail++;
         $error("FAIL busy_request: op %0d issued while busy", op);
      end
      if (rst) begin
         m_hi = '0; m_lo = '0; m_left = 0; m_pend_wr = 1'b0;
      end else if (m_left != 0) begin
         if (m_left == 1 && m_pend_wr) {m_hi, m_lo} = m_pend;
         m_left--;
      end else if (exp_start) begin
         ref_result(op, a, b, r, w);
         m_pend    = r;
         m_pend_wr = w;
         m_left    = (op >= 4'd3) ? NDIV : NMUL;
      end else if (op == 4'd5) begin
         m_hi = a;
      end else if (op == 4'd6) begin
         m_lo = a;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc(4'd0, $urandom, $urandom, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int unsigned nb;
      logic [3:0]  op;
      reset = 1'b1; EX_MDOp = '0; EX_A = '0; EX_B = '0; ID_isMD = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0; m_pend = '0; m_pend_wr = 1'b0;
      last_stall = 1'b0; last_start = 1'b0;
      @(posedge clk);
      #1;
      cyc(4'd0, '0, '0, 1'b0, 1'b1);
      chk("reset_HI", 64'(HI), 64'h0);
      chk("reset_LO", 64'(LO), 64'h0);
      chk("reset_busy", 64'(MD_busy), 64'h0);

      // 1: signed multiply, exact busy window length
      cyc(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
      nb = 0;
      while (MD_busy === 1'b1 && nb < 20) begin
         nb++;
         cyc(4'd0, '0, '0, 1'b0, 1'b0);
      end
      chk("mult_busy_cycles", 64'(nb), 64'd5);
      chk("mult_HI", 64'(HI), 64'hFFFF_FFFF);
      chk("mult_LO", 64'(LO), 64'hFFFF_FFFA);

      // 2: unsigned multiply, result visible in cycle k+6
      cyc(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      idle(5);
      chk("multu_HI", 64'(HI), 64'hFFFF_FFFE);
      chk("multu_LO", 64'(LO), 64'h1);

      // 3: signed divide, then divide by zero keeps preloaded HI/LO
      cyc(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      idle(10);
      chk("div_LO", 64'(LO), 64'hFFFF_FFFD);
      chk("div_HI", 64'(HI), 64'hFFFF_FFFF);
      cyc(4'd5, 32'h11, '0, 1'b0, 1'b0);
      cyc(4'd6, 32'h22, '0, 1'b0, 1'b0);
      cyc(4'd4, 32'h1234, 32'h0, 1'b0, 1'b0);
      chk("divz_busy", 64'(MD_busy), 64'h1);
      idle(10);
      chk("divz_busy_end", 64'(MD_busy), 64'h0);
      chk("divz_HI", 64'(HI), 64'h11);
      chk("divz_LO", 64'(LO), 64'h22);

      // signed divide overflow case
      cyc(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      idle(10);
      chk("divovf_LO", 64'(LO), 64'h8000_0000);
      chk("divovf_HI", 64'(HI), 64'h0);

      // 4: mult with an MD instruction waiting in ID
      cyc(4'd1, 32'd7, 32'd9, 1'b1, 1'b0);
      chk("stall_k", 64'(last_stall), 64'h1);
      for (int unsigned i = 1; i <= 5; i++) begin
         cyc(4'd0, '0, '0, 1'b1, 1'b0);
         chk($sformatf("stall_k+%0d", i), 64'(last_stall), 64'h1);
      end
      cyc(4'd8, '0, '0, 1'b1, 1'b0);
      chk("stall_k+6", 64'(last_stall), 64'h0);
      chk("mflo_after_mult", 64'(LO), 64'd63);

      // 5: back-to-back move-to, then mfhi
      cyc(4'd5, 32'h1234, '0, 1'b0, 1'b0);
      cyc(4'd6, 32'h5678, '0, 1'b0, 1'b0);
      chk("mt_busy", 64'(MD_busy), 64'h0);
      chk("mthi", 64'(HI), 64'h1234);
      chk("mtlo", 64'(LO), 64'h5678);
      cyc(4'd7, '0, '0, 1'b1, 1'b0);
      chk("mfhi_out", 64'(MD_out), 64'h1234);
      chk("mfhi_nostall", 64'(last_stall), 64'h0);

      // 6: reset in cycle k+3 of a divide abandons it
      cyc(4'd4, 32'd100, 32'd7, 1'b0, 1'b0);
      idle(2);
      cyc(4'd0, '0, '0, 1'b0, 1'b1);
      chk("rst_mid_busy", 64'(MD_busy), 64'h0);
      chk("rst_mid_HI", 64'(HI), 64'h0);
      chk("rst_mid_LO", 64'(LO), 64'h0);
      idle(12);
      chk("rst_nocommit_HI", 64'(HI), 64'h0);
      chk("rst_nocommit_LO", 64'(LO), 64'h0);

      // Random traffic respecting the stall contract
      for (int unsigned i = 0; i < 600; i++) begin
         if (m_left != 0) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'd0;
         end else begin
            op = 4'($urandom_range(0, 15));
         end
         cyc(op, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 79) == 0));
      end
      idle(12);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the forwarded rs/rt operands and the MD opcode produced by the ID/EX register.
- Holds the architectural HI/LO registers and supplies mfhi/mflo data to the EX result mux.
- Raises a stall request to the hazard unit whenever an MD-class instruction in ID must wait for the unit.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- EX_MDOp  input  4  MD opcode of the EX instruction: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 are treated as none.
- EX_A  input  32  forwarded rs value.
- EX_B  input  32  forwarded rt value.
- ID_isMD  input  1  instruction currently in ID has MDOp != 0.
- MD_busy  output  1  unit is computing.
- MD_start  output  1  combinational; EX_MDOp is 1-4.
- MD_stall  output  1  combinational; equals ID_isMD & (MD_start | MD_busy).
- MD_out  output  32  combinational; HI when EX_MDOp==7, LO when EX_MDOp==8, else 0.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset: all outputs and internal state are cleared on the clock edge.
  - HI=0, LO=0, MD_busy=0, counter=0, state=IDLE.
  - Any in-flight result is discarded.
- States:
  - IDLE: MD_busy=0.
  - RUN: MD_busy=1; a down-counter holds the remaining cycles.
- Start of an operation:
  - Condition: state is IDLE and MD_start=1 in cycle k.
  - At the edge ending cycle k: operands are latched, the 64-bit result is computed into shadow registers, counter is loaded with N (MULT_CYCLES or DIV_CYCLES), and state goes to RUN.
- Busy window and commit:
  - MD_busy is high in cycles k+1 through k+N.
  - The counter decrements once per cycle in RUN.
  - At the edge where counter==1, the shadow is committed to HI/LO and state returns to IDLE.
  - The new HI/LO values and MD_busy=0 are visible from cycle k+N+1.
- Multiply results:
  - mult: {HI,LO} = signed(A) * signed(B), full 64 bits.
  - multu: {HI,LO} = unsigned 64-bit product.
- Divide results:
  - div: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - div, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient in LO, unsigned remainder in HI.
  - Divide by zero (div or divu): HI/LO are left unchanged at commit; the unit still occupies DIV_CYCLES.
- Move-to instructions:
  - mthi/mtlo in IDLE: HI (or LO) <= EX_A at the next edge, with no busy window.
- Requests while busy:
  - A start, mthi or mtlo while MD_busy=1 is ignored; state and HI/LO are unaffected.
  - The hazard unit guarantees this never happens through MD_stall; the bench flags it with an assertion.
- mfhi/mflo:
  - MD_out is purely combinational from the current HI/LO registers.
  - Stalling guarantees they never read while busy.
- Stall timing:
  - MD_stall is asserted in the start cycle itself, so an MD instruction directly behind a mult is held in ID.
  - MD_stall drops in cycle k+N+1.
- Reset mid-operation: abandons the computation; the unit is in IDLE with HI=LO=0 the following cycle.
- Widths:
  - Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
  - Shadow result registers are 64 bits.

Decomposition:
- Shared package (mdu_defs):
  - MDOp encodings MD_NONE..MD_MFLO, 4 bits.
  - State encodings IDLE and RUN.
  - Default latency constants.
- One sub-module, mdu_calc: combinational 64-bit signed/unsigned product and quotient/remainder, including the div-by-zero and overflow special cases.
- The ex_mdu top module holds the FSM, counter, shadow registers and HI/LO.

Test Plan:
1. mult: A=0xFFFFFFFE (-2), B=3 -> MD_busy for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. multu: A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 in cycle k+6.
3. div: A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with B=0, HI=0x11, LO=0x22 preloaded -> unchanged after 10 cycles.
4. mult followed by ID_isMD=1 (mflo) -> MD_stall=1 in cycles k..k+5 and 0 in k+6; mflo then returns the committed LO on MD_out.
5. mthi A=0x1234 then mtlo A=0x5678 on consecutive cycles -> HI=0x1234, LO=0x5678 with MD_busy never asserted. mfhi gives MD_out=0x1234.
6. reset pulsed in cycle k+3 of a div -> next cycle MD_busy=0, HI=LO=0; no commit ever appears.
